sb_config_loader: RTL and testbench



---
 rtl/sb_config_loader.sv | 118 +++++++++++
 tb/tb_sb_config_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_config_loader.sv
// Switch box configuration loader: assembles a word stream into a shadow
// register, validates it against a trailing XOR checksum, and only then
// commits it atomically to config_out.
module sb_config_loader #(
  parameter int unsigned CONFIG_WIDTH = 112,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CNT_W-1:0]        count;
  logic [WORD_WIDTH-1:0]   csum;
  logic                    xfer;
  logic                    take;
  logic                    load_go;

  assign xfer    = word_valid & word_ready;
  // An abort discards whatever word is presented in the same cycle.
  assign take    = xfer & ~abort;
  assign load_go = (state == IDLE) & start & ~abort;

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) state_next = LOAD;
      end
      LOAD: begin
        if (abort)                          state_next = IDLE;
        else if (xfer && count == LAST_IDX) state_next = CHECK;
      end
      CHECK: begin
        if (abort)     state_next = IDLE;
        else if (xfer) state_next = (word_in == csum) ? COMMIT : IDLE;
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    word_ready = (state == LOAD) || (state == CHECK);
    busy       = (state != IDLE);
  end

  // Datapath: shadow assembly, running checksum, commit and status flags
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shadow     <= '0;
      count      <= '0;
      csum       <= '0;
      config_out <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_go) begin
            count <= '0;
            csum  <= '0;
            error <= 1'b0;
          end
        end
        LOAD: begin
          if (take) begin
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
              if (count == CNT_W'(k)) shadow[k*WORD_WIDTH +: WORD_WIDTH] <= word_in;
            end
            csum  <= csum ^ word_in;
            count <= count + 1'b1;
          end
        end
        CHECK: begin
          if (take && (word_in != csum)) error <= 1'b1;
        end
        COMMIT: begin
          config_out <= shadow;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Self-checking bench for sb_config_loader: directed corner sequences,
// a table of load vectors and randomized loads against a stream model.
module tb_sb_config_loader;

  localparam int unsigned CW = 112;
  localparam int unsigned WW = 8;

  typedef logic [7:0] stream_t [15];

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    bit         corrupt;
    bit         gaps;
    bit         exp_err;
  } vec_t;

  logic          clock;
  logic          nreset;
  logic          start;
  logic          abort;
  logic [WW-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] config_out;
  logic          busy;
  logic          done;
  logic          error;

  int unsigned n_cmp;
  int unsigned n_fail;
  logic [CW-1:0] exp_cfg;

  sb_config_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH  (WW)
  ) dut (
    .clock     (clock),
    .nreset    (nreset),
    .start     (start),
    .abort     (abort),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .config_out(config_out),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: payload word k occupies bits [8k+7:8k].
  function automatic logic [CW-1:0] pack(input stream_t w);
    logic [CW-1:0] r;
    r = '0;
    for (int k = 13; k >= 0; k--) r = (r << 8) | CW'(w[k]);
    return r;
  endfunction

  function automatic logic [7:0] xsum(input stream_t w);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 14; k++) x = x ^ w[k];
    return x;
  endfunction

  task automatic do_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", word_ready, 1);
    chk("error_cleared_on_start", error, 0);
  endtask

  // Presents w[from..to]; returns at posedge+1 after the last transfer.
  task automatic send_words(input stream_t w, input int from, input int to, input bit gaps);
    int idx;
    int budget;
    idx = from;
    budget = 400;
    while (idx <= to && budget > 0) begin
      word_in    = w[idx];
      word_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (word_valid && word_ready) idx++;
      @(posedge clock); #1;
      budget--;
    end
    word_valid = 1'b0;
    word_in    = '0;
    chk("transfer_budget", (idx > to) ? 1 : 0, 1);
  endtask

  task automatic finish_check(input stream_t w, input bit exp_ok);
    @(negedge clock);
    if (exp_ok) begin
      chk("commit_busy", busy, 1);
      chk("commit_ready", word_ready, 0);
      chk("commit_done_early", done, 0);
      chk("commit_cfg_unchanged", config_out, exp_cfg);
      exp_cfg = pack(w);
      @(negedge clock);
      chk("done_pulse", done, 1);
      chk("busy_fall_with_done", busy, 0);
      chk("cfg_committed", config_out, exp_cfg);
      chk("no_error", error, 0);
      @(negedge clock);
      chk("done_single_cycle", done, 0);
    end else begin
      chk("mismatch_error", error, 1);
      chk("mismatch_busy", busy, 0);
      chk("mismatch_done", done, 0);
      chk("mismatch_cfg_kept", config_out, exp_cfg);
      @(negedge clock);
      chk("mismatch_no_done", done, 0);
      chk("error_sticky", error, 1);
    end
  endtask

  task automatic run_load(input stream_t w, input bit gaps, input bit exp_ok);
    do_start();
    send_words(w, 0, 14, gaps);
    finish_check(w, exp_ok);
  endtask

  stream_t s;
  vec_t    vecs [6];

  initial begin
    n_cmp = 0; n_fail = 0;
    exp_cfg = '0;
    nreset = 1'b0; start = 1'b0; abort = 1'b0; word_in = '0; word_valid = 1'b0;

    vecs[0] = '{base: 8'h01, step: 8'h01, corrupt: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[1] = '{base: 8'h01, step: 8'h01, corrupt: 1'b1, gaps: 1'b0, exp_err: 1'b1};
    vecs[2] = '{base: 8'h10, step: 8'h11, corrupt: 1'b0, gaps: 1'b1, exp_err: 1'b0};
    vecs[3] = '{base: 8'hFF, step: 8'h00, corrupt: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[4] = '{base: 8'hA5, step: 8'h3C, corrupt: 1'b1, gaps: 1'b1, exp_err: 1'b1};
    vecs[5] = '{base: 8'h00, step: 8'h00, corrupt: 1'b0, gaps: 1'b1, exp_err: 1'b0};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cfg", config_out, '0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    nreset = 1'b1;

    // Full load 0x01..0x0E with checksum 0x0F
    for (int k = 0; k < 14; k++) s[k] = 8'(k + 1);
    s[14] = 8'h0F;
    do_start();
    send_words(s, 0, 14, 1'b0);
    @(negedge clock);
    chk("s1_commit_cycle_busy", busy, 1);
    chk("s1_cfg_before_done", config_out, '0);
    @(negedge clock);
    chk("s1_done", done, 1);
    chk("s1_cfg", config_out, 112'h0E0D0C0B0A090807060504030201);
    @(negedge clock);
    chk("s1_done_clear", done, 0);

    // Reset, then same payload with bad checksum 0x00
    nreset = 1'b0; #3; nreset = 1'b1;
    exp_cfg = '0;
    s[14] = 8'h00;
    run_load(s, 1'b0, 1'b0);

    // Valid-toggling load reaches the same configuration
    s[14] = 8'h0F;
    do_start();
    for (int k = 0; k < 15; k++) begin
      word_in = s[k]; word_valid = 1'b0;
      @(posedge clock); #1;
      word_valid = 1'b1;
      @(posedge clock); #1;
    end
    word_valid = 1'b0;
    finish_check(s, 1'b1);
    chk("toggle_cfg", config_out, 112'h0E0D0C0B0A090807060504030201);

    // All ones committed, then second load aborted after five words
    for (int k = 0; k < 14; k++) s[k] = 8'hFF;
    s[14] = 8'h00;
    run_load(s, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) s[k] = 8'h3C;
    do_start();
    send_words(s, 0, 4, 1'b0);
    abort = 1'b1; word_valid = 1'b1; word_in = 8'h77;
    @(posedge clock); #1;
    abort = 1'b0; word_valid = 1'b0;
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_cfg_ones", config_out, {CW{1'b1}});

    // start+abort together in IDLE: no state change
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_ready", word_ready, 0);

    // start pulse mid-load is ignored
    for (int k = 0; k < 14; k++) s[k] = 8'(8'h40 + 8'(k * 3));
    s[14] = xsum(s);
    do_start();
    send_words(s, 0, 6, 1'b0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_in_load_busy", busy, 1);
    send_words(s, 7, 14, 1'b0);
    finish_check(s, 1'b1);

    // Reset asserted during the COMMIT cycle
    for (int k = 0; k < 14; k++) s[k] = 8'(8'hC0 ^ k);
    s[14] = xsum(s);
    do_start();
    send_words(s, 0, 14, 1'b0);
    chk("pre_rst_commit_busy", busy, 1);
    nreset = 1'b0;
    #1;
    exp_cfg = '0;
    chk("rst_commit_cfg", config_out, exp_cfg);
    chk("rst_commit_done", done, 0);
    chk("rst_commit_busy", busy, 0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    chk("post_rst_done", done, 0);
    chk("post_rst_cfg", config_out, exp_cfg);

    // Table of load vectors
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 14; k++) s[k] = 8'(vecs[v].base + 8'(vecs[v].step * k));
      s[14] = xsum(s) ^ (vecs[v].corrupt ? 8'h5A : 8'h00);
      run_load(s, vecs[v].gaps, !vecs[v].exp_err);
    end

    // Randomized loads against the stream model
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 14; k++) s[k] = 8'($urandom);
      s[14] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : xsum(s);
      run_load(s, 1'($urandom_range(0, 1)), s[14] == xsum(s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
